updown_pulse_sched: RTL and testbench
=====================================

UPDOWN_PULSE_SCHED -- requirements
Module: updown_pulse_sched

Interface
REQ-001 Parameter HI_CYC, default 2: CLK_DRV cycles each UP/DOWN/CLR pulse and LOAD_N strobe is active (range 1..15).
REQ-002 Parameter LO_CYC, default 2: CLK_DRV recovery cycles after each active phase (range 1..15).
REQ-003 Parameter MAX_POS, default 8'hFF: upper saturation limit of the driven counter pair.
REQ-004 Parameter MIN_POS, default 8'h00: lower saturation limit.
REQ-005 CLK_DRV  in  1  the single clock for all logic.
REQ-006 RST_N  in  1  asynchronous reset, active low.
REQ-007 TICK  in  1  one-cycle pacing strobe; count pulses start only on a TICK.
REQ-008 REQ_UP_A, REQ_DN_A  in  1 each  requester A (player) level requests.
REQ-009 REQ_UP_B, REQ_DN_B  in  1 each  requester B (auto-return) level requests.
REQ-010 LOAD_REQ  in  1  one-cycle load strobe.
REQ-011 LOAD_VAL  in  8  preset value, captured on the LOAD_REQ cycle.
REQ-012 CLR_REQ  in  1  one-cycle clear strobe.
REQ-013 POS  in  8  current counter pair value {high QD..QA, low QD..QA}.
REQ-014 UP, DOWN  out  1 each  count pulses to the low counter, active high, idle 0.
REQ-015 LOAD_N  out  1  parallel load to both counters, active low, idle 1.
REQ-016 CLR  out  1  clear to both counters, active high, idle 0.
REQ-017 DATA  out  8  load data; holds captured LOAD_VAL.
REQ-018 GNT_A, GNT_B  out  1 each  one-cycle grant pulse when that requester's pulse starts.
REQ-019 BUSY  out  1  high whenever FSM is not IDLE.

Function
REQ-020 FSM states: IDLE, ACTIVE, RECOVER; ACTIVE drives exactly one of UP, DOWN, CLR, or LOAD_N low, selected by a registered op code.
REQ-021 ACTIVE lasts HI_CYC cycles, then RECOVER lasts LO_CYC cycles with all outputs idle, then IDLE.
REQ-022 CLR_REQ and LOAD_REQ set sticky pending flags; flags clear when their op enters ACTIVE.
REQ-023 LOAD_REQ while a load is already pending overwrites the captured LOAD_VAL.
REQ-024 Priority from IDLE, per cycle: pending clear, then pending load (neither waits for TICK), then count request only on a TICK cycle.
REQ-025 Op decided in cycle N enters ACTIVE with output asserted in cycle N+1.
REQ-026 Requester with both UP and DN high is treated as not requesting.
REQ-027 UP request ineligible when POS >= MAX_POS; DN request ineligible when POS <= MIN_POS.
REQ-028 A and B eligible on the same TICK: round-robin, the requester not granted last wins; pointer starts favouring A after reset.
REQ-029 Grant pulse is asserted in cycle N+1 with the count pulse start; pointer updates then.
REQ-030 Count requests not eligible on a TICK are dropped, not queued.
REQ-031 TICK during ACTIVE or RECOVER is ignored.
REQ-032 DATA changes only on LOAD_REQ capture; stable throughout LOAD_N low.

Reset
REQ-033 RST_N low immediately forces IDLE, UP=0, DOWN=0, CLR=0, LOAD_N=1, DATA=0, GNT_A=GNT_B=0, BUSY=0, pending flags cleared, pointer to A, including mid-pulse.
REQ-034 After RST_N deasserts, first op may start on the first clock edge.

Verification
REQ-035 HI_CYC=2, LO_CYC=2, POS=8'h10, REQ_UP_A=1, TICK at cycle 5 -> UP high cycles 6-7, GNT_A cycle 6, BUSY cycles 6-9, TICK at 8 ignored.
REQ-036 REQ_DN_A=1 and REQ_UP_B=1 continuous, TICK every 10 cycles -> grants alternate A,B,A,B; DOWN and UP pulses alternate.
REQ-037 POS=8'hFF, REQ_UP_A=1, TICK -> no UP, no GNT_A, BUSY stays 0; POS=8'h00 with REQ_DN_B likewise.
REQ-038 During an UP pulse, CLR_REQ then LOAD_REQ with LOAD_VAL=8'h5A -> after RECOVER, CLR high 2 cycles, recover, then LOAD_N low 2 cycles with DATA=8'h5A.
REQ-039 RST_N low during cycle 1 of LOAD_N low -> LOAD_N=1, DATA=0, BUSY=0 within the same cycle, no load after release.
REQ-040 REQ_UP_A=REQ_DN_A=1, TICK -> no pulse, no grant.

Source files
------------

// File: rtl/updown_pulse_sched.sv
// Sequences UP/DOWN/CLR/LOAD_N pulses to an 8-bit counter pair: clear > load > TICK-paced count, A/B round-robin.
// An op decided in cycle N drives its output from N+1 for HI_CYC cycles, then LO_CYC recovery; TICKs while busy are ignored.
module updown_pulse_sched #(
   parameter int          HI_CYC  = 2,
   parameter int          LO_CYC  = 2,
   parameter logic [7:0]  MAX_POS = 8'hFF,
   parameter logic [7:0]  MIN_POS = 8'h00
) (
   input  logic       clk_drv_i,
   input  logic       rst_n_i,
   input  logic       tick_i,
   input  logic       req_up_a_i,
   input  logic       req_dn_a_i,
   input  logic       req_up_b_i,
   input  logic       req_dn_b_i,
   input  logic       load_req_i,
   input  logic [7:0] load_val_i,
   input  logic       clr_req_i,
   input  logic [7:0] pos_i,
   output logic       up_o,
   output logic       down_o,
   output logic       load_n_o,
   output logic       clr_o,
   output logic [7:0] data_o,
   output logic       gnt_a_o,
   output logic       gnt_b_o,
   output logic       busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RECOVER} state_t;
   typedef enum logic [1:0] {OP_UP, OP_DN, OP_CLR, OP_LD} op_t;

   localparam logic [3:0] HI_M1 = 4'(HI_CYC - 1);
   localparam logic [3:0] LO_M1 = 4'(LO_CYC - 1);

   state_t     state_q, state_d;
   op_t        op_q, op_d;
   logic [3:0] cnt_q, cnt_d;
   logic       clr_pend_q, clr_pend_d;
   logic       ld_pend_q, ld_pend_d;
   logic       fav_b_q, fav_b_d;
   logic       gnt_a_q, gnt_a_d;
   logic       gnt_b_q, gnt_b_d;
   logic [7:0] data_q, data_d;
   logic [7:0] sh_q, sh_d;
   logic       sh_vld_q, sh_vld_d;

   logic a_up, a_dn, b_up, b_dn, can_up, can_dn, a_elig, b_elig, pick_b;
   logic clr_eff, ld_eff, ld_act, ld_last, ld_hold;

   // Both directions high from one requester cancels out to no request.
   assign a_up   = req_up_a_i & ~req_dn_a_i;
   assign a_dn   = req_dn_a_i & ~req_up_a_i;
   assign b_up   = req_up_b_i & ~req_dn_b_i;
   assign b_dn   = req_dn_b_i & ~req_up_b_i;
   assign can_up = pos_i < MAX_POS;
   assign can_dn = pos_i > MIN_POS;
   assign a_elig = (a_up & can_up) | (a_dn & can_dn);
   assign b_elig = (b_up & can_up) | (b_dn & can_dn);
   assign pick_b = b_elig & (~a_elig | fav_b_q);

   assign clr_eff = clr_pend_q | clr_req_i;
   assign ld_eff  = ld_pend_q | load_req_i;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      clr_pend_d = clr_eff;
      ld_pend_d  = ld_eff;
      fav_b_d    = fav_b_q;
      gnt_a_d    = 1'b0;
      gnt_b_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clr_eff) begin
               state_d    = S_ACTIVE;
               op_d       = OP_CLR;
               cnt_d      = HI_M1;
               clr_pend_d = 1'b0;
            end else if (ld_eff) begin
               state_d   = S_ACTIVE;
               op_d      = OP_LD;
               cnt_d     = HI_M1;
               ld_pend_d = 1'b0;
            end else if (tick_i && (a_elig || b_elig)) begin
               state_d = S_ACTIVE;
               cnt_d   = HI_M1;
               if (pick_b) begin
                  op_d    = b_up ? OP_UP : OP_DN;
                  gnt_b_d = 1'b1;
                  fav_b_d = 1'b0;
               end else begin
                  op_d    = a_up ? OP_UP : OP_DN;
                  gnt_a_d = 1'b1;
                  fav_b_d = 1'b1;
               end
            end
         end
         S_ACTIVE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RECOVER;
               cnt_d   = LO_M1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RECOVER: begin
            if (cnt_q == 4'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A capture arriving mid-load is parked so DATA stays frozen while LOAD_N is low.
   assign ld_act  = (state_q == S_ACTIVE) && (op_q == OP_LD);
   assign ld_last = ld_act && (cnt_q == 4'd0);
   assign ld_hold = ld_act && !ld_last;

   always_comb begin
      data_d   = data_q;
      sh_d     = sh_q;
      sh_vld_d = sh_vld_q;
      if (load_req_i && !ld_hold)   data_d = load_val_i;
      else if (ld_last && sh_vld_q) data_d = sh_q;
      if (load_req_i && ld_hold) begin
         sh_d     = load_val_i;
         sh_vld_d = 1'b1;
      end
      if (ld_last) sh_vld_d = 1'b0;
   end

   always_ff @(posedge clk_drv_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         op_q       <= OP_UP;
         cnt_q      <= 4'd0;
         clr_pend_q <= 1'b0;
         ld_pend_q  <= 1'b0;
         fav_b_q    <= 1'b0;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         data_q     <= 8'h00;
         sh_q       <= 8'h00;
         sh_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         clr_pend_q <= clr_pend_d;
         ld_pend_q  <= ld_pend_d;
         fav_b_q    <= fav_b_d;
         gnt_a_q    <= gnt_a_d;
         gnt_b_q    <= gnt_b_d;
         data_q     <= data_d;
         sh_q       <= sh_d;
         sh_vld_q   <= sh_vld_d;
      end
   end

   assign up_o     = (state_q == S_ACTIVE) && (op_q == OP_UP);
   assign down_o   = (state_q == S_ACTIVE) && (op_q == OP_DN);
   assign clr_o    = (state_q == S_ACTIVE) && (op_q == OP_CLR);
   assign load_n_o = !ld_act;
   assign data_o   = data_q;
   assign gnt_a_o  = gnt_a_q;
   assign gnt_b_o  = gnt_b_q;
   assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_updown_pulse_sched.sv
// Bench for updown_pulse_sched: fixed vector table, directed corner sequences, then random traffic vs a timeline model.
module tb_updown_pulse_sched;
   localparam int         HI   = 2;
   localparam int         LO   = 2;
   localparam logic [7:0] MAXP = 8'hFF;
   localparam logic [7:0] MINP = 8'h00;
   localparam int OP_UP = 0, OP_DN = 1, OP_CLR = 2, OP_LD = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, tick, up_a, dn_a, up_b, dn_b, ld, clr;
   logic [7:0] ldv, pos;
   logic       up, dn, ldn, clro, ga, gb, busy;
   logic [7:0] data;

   updown_pulse_sched #(.HI_CYC(HI), .LO_CYC(LO), .MAX_POS(MAXP), .MIN_POS(MINP)) dut (
      .clk_drv_i(clk), .rst_n_i(rst_n), .tick_i(tick),
      .req_up_a_i(up_a), .req_dn_a_i(dn_a), .req_up_b_i(up_b), .req_dn_b_i(dn_b),
      .load_req_i(ld), .load_val_i(ldv), .clr_req_i(clr), .pos_i(pos),
      .up_o(up), .down_o(dn), .load_n_o(ldn), .clr_o(clro), .data_o(data),
      .gnt_a_o(ga), .gnt_b_o(gb), .busy_o(busy));

   int checks = 0, errors = 0;
   int cyc = 0;

   // Model: an op is a time window [m_start, m_end) on the cycle axis, not a state machine.
   int         m_start, m_end, m_op, m_who;
   bit         m_clr_p, m_ld_p, m_fav_b;
   logic [7:0] m_data, m_latest;

   function automatic void model_reset();
      m_start = -100; m_end = -100; m_op = OP_UP; m_who = 0;
      m_clr_p = 0; m_ld_p = 0; m_fav_b = 0; m_data = 8'h00; m_latest = 8'h00;
   endfunction

   function automatic int dir_of(bit u, bit d);
      if (u && !d) return 1;
      if (d && !u) return 2;
      return 0;
   endfunction

   function automatic bit elig(int dir, logic [7:0] p);
      return (dir == 1 && p < MAXP) || (dir == 2 && p > MINP);
   endfunction

   function automatic void start_op(int now, int op, int who);
      m_start = now + 1; m_end = now + 1 + HI + LO; m_op = op; m_who = who;
   endfunction

   function automatic void model_edge();
      int now, dra, drb;
      bit hold, ea, eb;
      now  = cyc;
      hold = (m_op == OP_LD) && now >= m_start && now < m_start + HI - 1;
      if (ld) m_latest = ldv;
      if (!hold) m_data = m_latest;
      if (clr) m_clr_p = 1;
      if (ld)  m_ld_p = 1;
      if (now >= m_end) begin
         dra = dir_of(up_a, dn_a); drb = dir_of(up_b, dn_b);
         ea = elig(dra, pos);      eb = elig(drb, pos);
         if (m_clr_p) begin
            start_op(now, OP_CLR, 0); m_clr_p = 0;
         end else if (m_ld_p) begin
            start_op(now, OP_LD, 0); m_ld_p = 0;
         end else if (tick && ea && (!eb || !m_fav_b)) begin
            start_op(now, (dra == 1) ? OP_UP : OP_DN, 1); m_fav_b = 1;
         end else if (tick && eb) begin
            start_op(now, (drb == 1) ? OP_UP : OP_DN, 2); m_fav_b = 0;
         end
      end
   endfunction

   function automatic logic [14:0] exp_vec();
      bit act, bsy;
      act = cyc >= m_start && cyc < m_start + HI;
      bsy = cyc >= m_start && cyc < m_end;
      return {act && m_op == OP_UP, act && m_op == OP_DN, !(act && m_op == OP_LD),
              act && m_op == OP_CLR, cyc == m_start && m_who == 1,
              cyc == m_start && m_who == 2, bsy, m_data};
   endfunction

   function automatic logic [14:0] act_vec();
      return {up, dn, ldn, clro, ga, gb, busy, data};
   endfunction

   task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      check("model", act_vec(), exp_vec());
   endtask

   task automatic idle_inputs();
      tick = 0; up_a = 0; dn_a = 0; up_b = 0; dn_b = 0;
      ld = 0; clr = 0; ldv = 8'h00; pos = 8'h10;
   endtask

   task automatic do_reset();
      rst_n = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
      check("reset", act_vec(), {7'b0010000, 8'h00});
   endtask

   typedef struct {
      bit tick, ua, da, ub, db;
      logic [7:0] pos;
      bit e_up, e_dn, e_ga, e_gb, e_busy;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(bit t, bit ua, bit da, bit ub, bit db, logic [7:0] p,
                               bit eu, bit ed, bit ega, bit egb, bit eb);
      vec_t v;
      v.tick = t; v.ua = ua; v.da = da; v.ub = ub; v.db = db; v.pos = p;
      v.e_up = eu; v.e_dn = ed; v.e_ga = ega; v.e_gb = egb; v.e_busy = eb;
      return v;
   endfunction

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int clr_n, ld_n, ld_ok, first_clr, first_ld;
      bit ld_seen;
      rst_n = 0;
      idle_inputs();
      model_reset();

      // Single UP pulse, ignored TICK while recovering, then blocked/cancelled requests and round-robin.
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,0,0,0,8'h10, 0,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,8'h10, 1,0,1,0,1));
      tbl.push_back(mk(0,1,0,0,0,8'h10, 1,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,8'h10, 0,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,0,8'h10, 0,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,8'h10, 0,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,8'h10, 0,0,0,0,0));
      tbl.push_back(mk(1,1,1,0,0,8'h10, 0,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,8'hFF, 0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,1,8'h00, 0,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,1,8'h00, 1,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h00, 1,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h00, 0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h00, 0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h00, 0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,1,8'h10, 0,1,0,1,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 0,1,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 0,0,0,0,0));
      tbl.push_back(mk(1,1,0,1,0,8'h10, 1,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 1,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 0,0,0,0,0));
      tbl.push_back(mk(1,1,0,1,0,8'h10, 1,0,0,1,1));
      tbl.push_back(mk(0,0,0,0,0,8'h10, 1,0,0,0,1));

      @(negedge clk);
      do_reset();
      foreach (tbl[i]) begin
         tick = tbl[i].tick; up_a = tbl[i].ua; dn_a = tbl[i].da;
         up_b = tbl[i].ub; dn_b = tbl[i].db; pos = tbl[i].pos;
         step();
         check($sformatf("tbl_row%0d", i), {8'h00, up, dn, ga, gb, busy, ldn, clro},
               {8'h00, tbl[i].e_up, tbl[i].e_dn, tbl[i].e_ga, tbl[i].e_gb, tbl[i].e_busy, 1'b1, 1'b0});
      end
      idle_inputs();
      repeat (4) step();

      // Continuous A-down / B-up with periodic TICK: grants alternate starting at A.
      do_reset();
      dn_a = 1; up_b = 1; pos = 8'h10;
      for (int k = 0; k < 4; k++) begin
         tick = 1;
         step();
         tick = 0;
         check($sformatf("alt_gnt%0d", k), {11'h0, ga, gb, dn, up},
               {11'h0, (k % 2) == 0, (k % 2) == 1, (k % 2) == 0, (k % 2) == 1});
         repeat (9) step();
      end

      // Clear then load requested during an UP pulse: clear pulse first, then load with captured data.
      do_reset();
      up_a = 1; tick = 1;
      step();
      up_a = 0; tick = 0; clr = 1;
      step();
      clr = 0; ld = 1; ldv = 8'h5A;
      step();
      ld = 0; ldv = 8'h00;
      clr_n = 0; ld_n = 0; ld_ok = 0; first_clr = -1; first_ld = -1;
      for (int i = 0; i < 16; i++) begin
         step();
         if (clro) begin clr_n++; if (first_clr < 0) first_clr = i; end
         if (!ldn) begin
            ld_n++;
            if (first_ld < 0) first_ld = i;
            if (data == 8'h5A) ld_ok++;
         end
      end
      check("clr_len", 15'(clr_n), 15'd2);
      check("ld_len", 15'(ld_n), 15'd2);
      check("ld_data", 15'(ld_ok), 15'd2);
      check("clr_before_ld", 15'(first_clr >= 0 && first_clr < first_ld), 15'd1);

      // Reset asserted during the first LOAD_N-low cycle takes effect immediately.
      do_reset();
      ld = 1; ldv = 8'h33;
      step();
      ld = 0; ldv = 8'h00;
      check("ld_start", {6'h0, ldn, data}, {6'h0, 1'b0, 8'h33});
      #2 rst_n = 0;
      #1 check("rst_mid", act_vec(), {7'b0010000, 8'h00});
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
      ld_seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (!ldn) ld_seen = 1;
      end
      check("no_ld_after_rst", 15'(ld_seen), 15'd0);

      // Random traffic against the timeline model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         tick = ($urandom_range(0, 3) == 0);
         up_a = $urandom_range(0, 1); dn_a = $urandom_range(0, 1);
         up_b = $urandom_range(0, 1); dn_b = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       pos = MINP;
            1:       pos = MAXP;
            default: pos = 8'($urandom);
         endcase
         clr = ($urandom_range(0, 29) == 0);
         ld  = ($urandom_range(0, 19) == 0);
         ldv = 8'($urandom);
         if ($urandom_range(0, 499) == 0) do_reset();
         else step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
